// File: rtl/decrypt_pkg.sv
// Shared engine IDs, scheduler state encoding and delimiter default for the decrypt front end.
package decrypt_pkg;

  localparam logic [1:0] ENG_CAESAR  = 2'd0;
  localparam logic [1:0] ENG_SCYTALE = 2'd1;
  localparam logic [1:0] ENG_ZIGZAG  = 2'd2;
  localparam logic [1:0] ENG_NONE    = 2'd3;

  localparam logic [7:0] EOM_CHAR_DEFAULT = 8'hFA;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FORWARD,
    DISCARD,
    DRAIN_WAIT,
    DRAIN_BUSY,
    HOLD
  } sched_state_e;

  // States in which the scheduler refuses new bytes.
  function automatic logic is_draining(sched_state_e s);
    return (s == DRAIN_WAIT) || (s == DRAIN_BUSY) || (s == HOLD);
  endfunction

endpackage

// File: rtl/decrypt_scheduler_if.sv
// Byte-stream and engine-side signals of the decrypt scheduler; slave = scheduler, master = environment.
// Counter outputs exist only when DECRYPT_SCHED_MSG_CNT_EN is defined.
interface decrypt_scheduler_if #(
  parameter int unsigned D_WIDTH = 8
);
  logic [1:0]         select_i;
  logic [D_WIDTH-1:0] data_i;
  logic               valid_i;
  logic               busy_o;
  logic [D_WIDTH-1:0] data_o;
  logic               valid0_o;
  logic               valid1_o;
  logic               valid2_o;
  logic               busy0_i;
  logic               busy1_i;
  logic               busy2_i;
  logic [1:0]         mux_select_o;
  logic               err_o;
`ifdef DECRYPT_SCHED_MSG_CNT_EN
  logic [3*16-1:0]    msg_cnt_o;
  logic [15:0]        err_cnt_o;
`endif

  modport slave (
    input  select_i, data_i, valid_i, busy0_i, busy1_i, busy2_i,
    output busy_o, data_o, valid0_o, valid1_o, valid2_o, mux_select_o, err_o
`ifdef DECRYPT_SCHED_MSG_CNT_EN
    , output msg_cnt_o, err_cnt_o
`endif
  );

  modport master (
    output select_i, data_i, valid_i, busy0_i, busy1_i, busy2_i,
    input  busy_o, data_o, valid0_o, valid1_o, valid2_o, mux_select_o, err_o
`ifdef DECRYPT_SCHED_MSG_CNT_EN
    , input msg_cnt_o, err_cnt_o
`endif
  );

endinterface

// File: rtl/sched_hold_timer.sv
// Loadable down-counter that keeps the output mux frozen after the selected engine goes idle.
module sched_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);
  localparam int unsigned CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(HOLD_CYCLES);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // High when the decrement happening this cycle brings the count to zero.
  assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/decrypt_scheduler.sv
// Steers each whole message to one decrypt engine and owns the output mux select until it drains.
// Optional per-engine message / error counters: define DECRYPT_SCHED_MSG_CNT_EN.
module decrypt_scheduler
  import decrypt_pkg::*;
#(
  parameter int unsigned        D_WIDTH     = 8,
  parameter logic [D_WIDTH-1:0] EOM_CHAR    = D_WIDTH'(EOM_CHAR_DEFAULT),
  parameter int unsigned        HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  decrypt_scheduler_if.slave  bus
);

  sched_state_e       state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         mux_q, mux_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic [2:0]         fwd_q, fwd_d;
  logic               err_q, err_d;
  logic               busy_q;
  logic               busy_sel;
  logic               is_eom;
  logic               tmr_load, tmr_dec, tmr_done;

  sched_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .dec  (tmr_dec),
    .done (tmr_done)
  );

  assign is_eom = (bus.data_i == EOM_CHAR);

  always_comb begin
    case (sel_q)
      ENG_CAESAR:  busy_sel = bus.busy0_i;
      ENG_SCYTALE: busy_sel = bus.busy1_i;
      ENG_ZIGZAG:  busy_sel = bus.busy2_i;
      default:     busy_sel = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mux_d    = mux_q;
    data_d   = data_q;
    fwd_d    = 3'b000;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          sel_d = bus.select_i;
          if (bus.select_i == ENG_NONE) begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end else begin
            mux_d   = bus.select_i;
            data_d  = bus.data_i;
            fwd_d   = 3'b001 << bus.select_i;
            state_d = is_eom ? DRAIN_WAIT : FORWARD;
          end
        end
      end
      FORWARD: begin
        if (bus.valid_i) begin
          data_d = bus.data_i;
          fwd_d  = 3'b001 << sel_q;
          if (is_eom) state_d = DRAIN_WAIT;
        end
      end
      DISCARD: begin
        if (bus.valid_i && is_eom) state_d = IDLE;
      end
      DRAIN_WAIT: begin
        if (busy_sel) state_d = DRAIN_BUSY;
      end
      DRAIN_BUSY: begin
        if (!busy_sel) begin
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            tmr_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        tmr_dec = 1'b1;
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bytes offered while draining (including the last HOLD cycle) are dropped and flagged.
    if (is_draining(state_q) && bus.valid_i) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= ENG_CAESAR;
      mux_q   <= ENG_CAESAR;
      data_q  <= '0;
      fwd_q   <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mux_q   <= mux_d;
      data_q  <= data_d;
      fwd_q   <= fwd_d;
      err_q   <= err_d;
      busy_q  <= is_draining(state_d);
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.data_o       = data_q;
  assign bus.valid0_o     = fwd_q[0];
  assign bus.valid1_o     = fwd_q[1];
  assign bus.valid2_o     = fwd_q[2];
  assign bus.mux_select_o = mux_q;
  assign bus.err_o        = err_q;

`ifdef DECRYPT_SCHED_MSG_CNT_EN
  logic [CNT_W-1:0] msg_cnt_q [3];
  logic [CNT_W-1:0] err_cnt_q;
  logic             enter_drain;

  assign enter_drain = (state_d == DRAIN_WAIT) && (state_q != DRAIN_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) msg_cnt_q[i] <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (enter_drain && (sel_d == 2'(i))) msg_cnt_q[i] <= msg_cnt_q[i] + CNT_W'(1);
      end
      if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.msg_cnt_o = {msg_cnt_q[2], msg_cnt_q[1], msg_cnt_q[0]};
  assign bus.err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_decrypt_scheduler.sv
// Directed bench for decrypt_scheduler: message-level reference model compared every cycle plus literal spot checks.
module tb_decrypt_scheduler;

  localparam int         HOLD = 2;
  localparam logic [7:0] EOM  = 8'hFA;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  decrypt_scheduler_if #(.D_WIDTH(8)) bus ();

  decrypt_scheduler #(.D_WIDTH(8), .EOM_CHAR(EOM), .HOLD_CYCLES(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: tracks which message phase we are in and what the outputs must be.
  localparam int MP_IDLE = 0, MP_MSG = 1, MP_DROP = 2, MP_DRAIN = 3;
  int         m_phase;
  int         m_sel;
  bit         m_seen_busy;
  int         m_hold_left;
  logic [2:0] exp_valid;
  logic [7:0] exp_data;
  logic [1:0] exp_mux;
  logic       exp_err;
  logic       exp_busy;
  logic       m_busy_sel;
  logic       m_err_now;
`ifdef DECRYPT_SCHED_MSG_CNT_EN
  logic [15:0] exp_msg_cnt [3];
  logic [15:0] exp_err_cnt;
`endif

  assign exp_busy   = (m_phase == MP_DRAIN);
  assign m_busy_sel = (m_sel == 0) ? bus.busy0_i : (m_sel == 1) ? bus.busy1_i :
                      (m_sel == 2) ? bus.busy2_i : 1'b0;
  assign m_err_now  = bus.valid_i && ((m_phase == MP_IDLE && bus.select_i == 2'd3) ||
                                      m_phase == MP_DRAIN);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase     <= MP_IDLE;
      m_sel       <= 0;
      m_seen_busy <= 1'b0;
      m_hold_left <= -1;
      exp_valid   <= 3'b000;
      exp_data    <= 8'h00;
      exp_mux     <= 2'd0;
      exp_err     <= 1'b0;
`ifdef DECRYPT_SCHED_MSG_CNT_EN
      for (int i = 0; i < 3; i++) exp_msg_cnt[i] <= 16'd0;
      exp_err_cnt <= 16'd0;
`endif
    end else begin
      exp_valid <= 3'b000;
      exp_err   <= m_err_now;
`ifdef DECRYPT_SCHED_MSG_CNT_EN
      if (m_err_now && exp_err_cnt != 16'hFFFF) exp_err_cnt <= exp_err_cnt + 16'd1;
`endif
      case (m_phase)
        MP_IDLE: if (bus.valid_i) begin
          m_sel <= int'(bus.select_i);
          if (bus.select_i == 2'd3) begin
            m_phase <= MP_DROP;
          end else begin
            exp_valid <= 3'b001 << bus.select_i;
            exp_data  <= bus.data_i;
            exp_mux   <= bus.select_i;
            if (bus.data_i == EOM) begin
              m_phase     <= MP_DRAIN;
              m_seen_busy <= 1'b0;
              m_hold_left <= -1;
`ifdef DECRYPT_SCHED_MSG_CNT_EN
              exp_msg_cnt[bus.select_i] <= exp_msg_cnt[bus.select_i] + 16'd1;
`endif
            end else begin
              m_phase <= MP_MSG;
            end
          end
        end
        MP_MSG: if (bus.valid_i) begin
          exp_valid <= 3'b001 << m_sel;
          exp_data  <= bus.data_i;
          if (bus.data_i == EOM) begin
            m_phase     <= MP_DRAIN;
            m_seen_busy <= 1'b0;
            m_hold_left <= -1;
`ifdef DECRYPT_SCHED_MSG_CNT_EN
            exp_msg_cnt[m_sel] <= exp_msg_cnt[m_sel] + 16'd1;
`endif
          end
        end
        MP_DROP: if (bus.valid_i && bus.data_i == EOM) m_phase <= MP_IDLE;
        MP_DRAIN: begin
          if (!m_seen_busy) begin
            if (m_busy_sel) m_seen_busy <= 1'b1;
          end else if (m_hold_left < 0) begin
            if (!m_busy_sel) begin
              if (HOLD == 0) m_phase <= MP_IDLE;
              else           m_hold_left <= HOLD;
            end
          end else if (m_hold_left <= 1) begin
            m_phase <= MP_IDLE;
          end else begin
            m_hold_left <= m_hold_left - 1;
          end
        end
        default: m_phase <= MP_IDLE;
      endcase
    end
  end

  // Cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_o", bus.busy_o, exp_busy);
      check("mux_select_o", bus.mux_select_o, exp_mux);
      check("err_o", bus.err_o, exp_err);
      check("valid0_o", bus.valid0_o, exp_valid[0]);
      check("valid1_o", bus.valid1_o, exp_valid[1]);
      check("valid2_o", bus.valid2_o, exp_valid[2]);
      if (exp_valid != 3'b000) check("data_o", bus.data_o, exp_data);
`ifdef DECRYPT_SCHED_MSG_CNT_EN
      check("msg_cnt_o", bus.msg_cnt_o, {exp_msg_cnt[2], exp_msg_cnt[1], exp_msg_cnt[0]});
      check("err_cnt_o", bus.err_cnt_o, exp_err_cnt);
`endif
    end
  end

  // Drive one byte for one cycle; called and returning at a falling edge.
  task automatic send(input logic [1:0] sel, input logic [7:0] data);
    bus.select_i = sel;
    bus.data_i   = data;
    bus.valid_i  = 1'b1;
    @(negedge clk);
    bus.valid_i  = 1'b0;
  endtask

  task automatic set_busy(input int eng, input logic val);
    case (eng)
      0:       bus.busy0_i = val;
      1:       bus.busy1_i = val;
      default: bus.busy2_i = val;
    endcase
  endtask

  task automatic drain(input int eng, input int hi_cycles);
    int n;
    set_busy(eng, 1'b1);
    repeat (hi_cycles) @(negedge clk);
    set_busy(eng, 1'b0);
    n = 0;
    while (bus.busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", bus.busy_o, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy_o, 1'b0);
    check({tag, "_valids"}, {bus.valid2_o, bus.valid1_o, bus.valid0_o}, 3'b000);
    check({tag, "_data"}, bus.data_o, 8'h00);
    check({tag, "_mux"}, bus.mux_select_o, 2'd0);
    check({tag, "_err"}, bus.err_o, 1'b0);
  endtask

  initial begin
    bus.select_i = 2'd0;
    bus.data_i   = 8'h00;
    bus.valid_i  = 1'b0;
    bus.busy0_i  = 1'b0;
    bus.busy1_i  = 1'b0;
    bus.busy2_i  = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Engine 1 message, then drain with a violation during DRAIN_BUSY.
    send(2'd1, 8'h41);
    check("t1_valid1_b0", bus.valid1_o, 1'b1);
    check("t1_data_b0", bus.data_o, 8'h41);
    check("t1_mux", bus.mux_select_o, 2'd1);
    send(2'd1, 8'h42);
    check("t1_data_b1", bus.data_o, 8'h42);
    send(2'd1, EOM);
    check("t1_valid1_eom", bus.valid1_o, 1'b1);
    check("t1_busy_after_eom", bus.busy_o, 1'b1);
    check("model_mux", exp_mux, 2'd1);
    check("model_valid", exp_valid, 3'b010);
    bus.busy1_i = 1'b1;
    @(negedge clk);
    send(2'd0, 8'h77);
    check("t4_err", bus.err_o, 1'b1);
    check("t4_no_fwd", {bus.valid2_o, bus.valid1_o, bus.valid0_o}, 3'b000);
    check("t4_mux", bus.mux_select_o, 2'd1);
    repeat (3) @(negedge clk);
    bus.busy1_i = 1'b0;
    @(posedge clk); #1 check("t1_hold_e0", bus.busy_o, 1'b1);
    @(posedge clk); #1 check("t1_hold_e1", bus.busy_o, 1'b1);
    check("t1_hold_mux", bus.mux_select_o, 2'd1);
    @(posedge clk); #1 check("t1_idle_e2", bus.busy_o, 1'b0);
    @(negedge clk);

    // select_i changes mid-message are ignored.
    send(2'd0, 8'h10);
    check("t2_valid0_b0", bus.valid0_o, 1'b1);
    send(2'd2, 8'h11);
    check("t2_valid0_b1", bus.valid0_o, 1'b1);
    check("t2_valid2_b1", bus.valid2_o, 1'b0);
    send(2'd2, EOM);
    check("t2_mux", bus.mux_select_o, 2'd0);
    drain(0, 2);

    // Invalid engine: message discarded, then a good message to engine 2.
    send(2'd3, 8'h55);
    check("t3_err", bus.err_o, 1'b1);
    check("t3_no_fwd", {bus.valid2_o, bus.valid1_o, bus.valid0_o}, 3'b000);
    send(2'd3, EOM);
    check("t3_err_eom", bus.err_o, 1'b0);
    check("t3_not_busy", bus.busy_o, 1'b0);
    send(2'd2, 8'h20);
    check("t3_valid2", bus.valid2_o, 1'b1);
    check("t3_data", bus.data_o, 8'h20);
    send(2'd2, EOM);
    drain(2, 3);

    // Single-byte message; byte arriving as HOLD expires is a violation.
    send(2'd2, EOM);
    check("t5_valid2", bus.valid2_o, 1'b1);
    check("t5_busy", bus.busy_o, 1'b1);
    set_busy(2, 1'b1);
    repeat (2) @(negedge clk);
    set_busy(2, 1'b0);
    repeat (2) @(negedge clk);
    send(2'd0, 8'h33);
    check("t5_hold_err", bus.err_o, 1'b1);
    check("t5_hold_drop", bus.valid0_o, 1'b0);
    check("t5_idle", bus.busy_o, 1'b0);

    // Asynchronous reset mid-message, then a fresh message.
    send(2'd1, 8'h61);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'd0, 8'h30);
    check("t6_valid0", bus.valid0_o, 1'b1);
    check("t6_mux", bus.mux_select_o, 2'd0);
    send(2'd0, EOM);
    drain(0, 1);
`ifdef DECRYPT_SCHED_MSG_CNT_EN
    check("t6_msg_cnt", bus.msg_cnt_o, {16'd0, 16'd0, 16'd1});
`endif
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decrypt_scheduler.md
Name: decrypt_scheduler

Overview:
- Front-end sequencer for the three decryption engines: 0 = caesar, 1 = scytale, 2 = zigzag.
- Accepts one incoming byte stream and steers each whole message to the engine chosen by select_i.
- select_i is sampled once, on the first byte of a message. The scheduler then owns the output mux select until that engine has fully drained.
- Sits between the input interface/regfile and the three engines. It drives the select input of the output mux.

Parameters:
- D_WIDTH, 8, data byte width.
- EOM_CHAR, 8'hFA, end-of-message delimiter. It is forwarded to the engine as the last byte.
- HOLD_CYCLES, 2, cycles mux_select_o stays frozen after engine busy falls. Covers the 2-stage registered mux output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- select_i  in  2  requested engine, from regfile
- data_i  in  D_WIDTH  input byte
- valid_i  in  1  input byte valid
- busy_o  out  1  scheduler cannot accept bytes
- data_o  out  D_WIDTH  byte broadcast to all engines
- valid0_o / valid1_o / valid2_o  out  1 each  per-engine byte valid
- busy0_i / busy1_i / busy2_i  in  1 each  engine busy, high while emitting decrypted output
- mux_select_o  out  2  select for the output mux
- err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, all outputs 0, hold counter 0. Reset mid-message abandons it; bytes already forwarded to engines are not recalled.
- Forwarding latency: 1 cycle, registered. data_o is updated on every accepted byte.
- At most one validN_o is high in any cycle; all are 0 when not forwarding.
- IDLE (busy_o=0), on valid_i:
  - Latch sel=select_i.
  - If sel==3: pulse err_o and go to DISCARD. The byte is not forwarded.
  - Else: mux_select_o<=sel, forward the byte, go to FORWARD.
  - If that first byte == EOM_CHAR, go directly to DRAIN_WAIT.
- FORWARD (busy_o=0):
  - Every valid_i byte is forwarded to engine sel only.
  - select_i changes are ignored.
  - A byte == EOM_CHAR is forwarded, then the state moves to DRAIN_WAIT.
- DISCARD (busy_o=0): bytes are dropped. On EOM_CHAR return to IDLE. No engine valid is driven.
- DRAIN_WAIT (busy_o=1): wait for busy_sel==1.
- DRAIN_BUSY (busy_o=1): wait for busy_sel==0, then load hold counter = HOLD_CYCLES.
- HOLD (busy_o=1): decrement each cycle; at 0 go to IDLE.
- Across DRAIN_WAIT, DRAIN_BUSY and HOLD, mux_select_o stays = sel. In IDLE it keeps its last value until the next message starts.
- busy_o is registered: it asserts the cycle after the EOM byte is accepted.
- valid_i while busy_o=1 is a protocol violation: the byte is dropped and err_o pulses for 1 cycle. State is unchanged.
- If a byte arrives in the same cycle that HOLD reaches 0, it is a violation: dropped, err_o pulses.
- Busy inputs of non-selected engines are ignored.
- Hold counter width is $clog2(HOLD_CYCLES+1). With HOLD_CYCLES=0, DRAIN_BUSY exits directly to IDLE.

Optional Feature:
- Macro: DECRYPT_SCHED_MSG_CNT_EN.
- Defined:
  - Adds output msg_cnt_o [3*16-1:0]: three 16-bit counters, one per engine (engine 0 in bits [15:0]).
  - A counter increments when its engine enters DRAIN_WAIT and wraps 16'hFFFF→0.
  - Adds output err_cnt_o [15:0]: increments on each err_o pulse and saturates at 16'hFFFF.
  - All counters reset to 0.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Package decrypt_pkg holds:
  - Engine ID constants: ENG_CAESAR=2'd0, ENG_SCYTALE=2'd1, ENG_ZIGZAG=2'd2, ENG_NONE=2'd3.
  - The state enumeration: IDLE, FORWARD, DISCARD, DRAIN_WAIT, DRAIN_BUSY, HOLD.
  - EOM_CHAR default value.
- One sub-module: sched_hold_timer, a loadable down-counter with a done flag. Everything else is a single FSM module.

Test Plan:
- select_i=1; bytes 8'h41,8'h42,8'hFA → valid1_o high 1 cycle after each byte, data_o matches. mux_select_o=1 from the 1st forward. busy_o=1 after FA. Drive busy1_i 1 for 5 cycles then 0 → busy_o falls exactly 2 cycles later.
- select_i=0 for byte 1, then select_i=2 mid-message; bytes 8'h10,8'h11,8'hFA → all three routed to valid0_o only. valid2_o never asserts.
- select_i=3; bytes 8'h55,8'hFA → no engine valid, err_o pulse on the first byte, back to IDLE. Next message with select_i=2 routes to engine 2.
- valid_i during DRAIN_BUSY with 8'h77 → byte dropped, err_o pulse, mux_select_o unchanged.
- Single-byte message 8'hFA with select_i=2 → valid2_o once, direct entry to DRAIN_WAIT.
- rst_n=0 asserted mid-FORWARD (async, between edges) → all outputs 0 immediately. After release, new message with select_i=0 routes correctly. With the macro defined, msg_cnt_o increments only for completed messages.
